// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between two add/sub requesters, the shared arbiter and its consumer.
// Latency: none, wires only.
// Backpressure: valid/ready on each request port and on the response port.
interface addsub_arbiter_if #(
   parameter int W = 4
);
   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req0_m;

   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         req1_m;

   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_s;
   logic         rsp_c;
   logic         rsp_v;

   // Arbiter side: consumes requests, produces responses.
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_m,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_m,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_s, rsp_c, rsp_v,
      input  rsp_ready
   );

   // Requester/consumer side.
   modport master (
      output req0_valid, req0_a, req0_b, req0_m,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_m,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_s, rsp_c, rsp_v,
      output rsp_ready
   );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one ripple add/sub unit between two requesters, single-entry result register.
// Latency: accept in cycle N, result visible from cycle N+1; one op per cycle while rsp_ready is high.
// Backpressure: a full register with rsp_ready low drops both request readys.
module addsub_arbiter #(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   addsub_arbiter_if.slave  bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t       state;
   logic         last_grant;

   logic         rsp_id_q;
   logic [W-1:0] rsp_s_q;
   logic         rsp_c_q;
   logic         rsp_v_q;

   logic         win0;
   logic         win1;
   logic         can_accept;
   logic         accept;

   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_m;

   logic [W-1:0] sum;
   logic         carry;
   logic         bx;
   logic         c_msb;
   logic         c_raw;

   // Pick the winner: a lone requester wins, a tie goes to the port not granted last.
   always_comb begin
      win1       = bus.req1_valid & (~bus.req0_valid | ~last_grant);
      win0       = bus.req0_valid & ~win1;
      can_accept = (state == EMPTY) | bus.rsp_ready;
      accept     = (win0 | win1) & can_accept;
   end

   // Readys are held low while reset is asserted even though the register reads empty.
   assign bus.req0_ready = win0 & can_accept & rst_n;
   assign bus.req1_ready = win1 & can_accept & rst_n;

   // Steer the winner's operands into the shared datapath.
   always_comb begin
      op_a = win1 ? bus.req1_a : bus.req0_a;
      op_b = win1 ? bus.req1_b : bus.req0_b;
      op_m = win1 ? bus.req1_m : bus.req0_m;
   end

   // Ripple chain: A + (B ^ M) + M, recording the carry into the MSB for overflow.
   always_comb begin
      sum   = '0;
      c_msb = 1'b0;
      bx    = 1'b0;
      carry = op_m;
      for (int i = 0; i < W; i++) begin
         bx     = op_b[i] ^ op_m;
         sum[i] = op_a[i] ^ bx ^ carry;
         if (i == W - 1) begin
            c_msb = carry;
         end
         carry  = (op_a[i] & bx) | (carry & (op_a[i] ^ bx));
      end
      c_raw = carry;
   end

   // Output register FSM: load on accept, drain when the consumer takes the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         last_grant <= 1'b1;
         rsp_id_q   <= 1'b0;
         rsp_s_q    <= '0;
         rsp_c_q    <= 1'b0;
         rsp_v_q    <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state <= FULL;
               end
            end
            FULL: begin
               if (bus.rsp_ready && !accept) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
         if (accept) begin
            last_grant <= win1;
            rsp_id_q   <= win1;
            rsp_s_q    <= sum;
            rsp_c_q    <= c_raw ^ op_m;
            rsp_v_q    <= c_msb ^ c_raw;
         end
      end
   end

   assign bus.rsp_valid = (state == FULL);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_s     = rsp_s_q;
   assign bus.rsp_c     = rsp_c_q;
   assign bus.rsp_v     = rsp_v_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: directed cases, contention, stalls, random traffic, mid-run reset.
// Latency: expects each accepted op to surface one cycle after acceptance.
// Backpressure: drives random rsp_ready and keeps unaccepted requests stable.
module tb_addsub_arbiter;
   localparam int W = 4;

   logic clk;
   logic rst_n;

   addsub_arbiter_if #(.W(W)) bus ();

   addsub_arbiter #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [W+2:0] sbq[$];

   // reference state, advanced at the negedge before the DUT's next posedge
   bit full = 0;
   bit lg   = 1;
   bit acc0 = 0;
   bit acc1 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected response from plain integer arithmetic on the operands.
   function automatic logic [W+2:0] model(input bit id, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input bit m);
      int ua, ub, r, sa, sb, sr;
      bit c, v;
      logic [31:0] rr;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
      sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
      if (!m) begin
         r  = ua + ub;
         c  = (r >= (1 << W));
         sr = sa + sb;
      end else begin
         r  = ua - ub;
         c  = (ua < ub);
         sr = sa - sb;
      end
      v  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      rr = r;
      return {id, rr[W-1:0], c, v};
   endfunction

   // One clock of checking: compare handshake outputs with the reference, book accepts.
   task automatic eval_cycle();
      bit w, any, can, acc;
      @(negedge clk);
      chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, full});
      any = bus.req0_valid || bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) w = ~lg;
      else w = bus.req1_valid;
      can = !full || bus.rsp_ready;
      acc = any && can;
      chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, acc && !w});
      chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, acc && w});
      acc0 = acc && !w;
      acc1 = acc && w;
      if (acc) begin
         if (w) sbq.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_m));
         else   sbq.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_m));
         lg   = w;
         full = 1;
      end else if (full && bus.rsp_ready) begin
         full = 0;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input bit port, input bit v, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit m);
      if (!port) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_m = m;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_m = m;
      end
   endtask

   // Requests that are idle or were just accepted may change; pending ones stay put.
   task automatic drive_rand(input int pct_v, input int pct_r);
      if (!bus.req0_valid || acc0)
         set_req(1'b0, $urandom_range(99) < pct_v, W'($urandom), W'($urandom), 1'($urandom));
      if (!bus.req1_valid || acc1)
         set_req(1'b1, $urandom_range(99) < pct_v, W'($urandom), W'($urandom), 1'($urandom));
      bus.rsp_ready = $urandom_range(99) < pct_r;
   endtask

   // Monitor: whenever a result is presented, it must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rsp_unexpected: got id=%0d s=%0h with nothing outstanding at %0t",
                        bus.rsp_id, bus.rsp_s, $time);
            end else begin
               chk("rsp_data", {25'd0, bus.rsp_id, bus.rsp_s, bus.rsp_c, bus.rsp_v}, {25'd0, sbq[0]});
               if (bus.rsp_ready) void'(sbq.pop_front());
            end
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      bus.rsp_ready = 1'b0;
      set_req(1'b0, 1'b1, 4'b1111, 4'b0110, 1'b0);
      set_req(1'b1, 1'b0, '0, '0, 1'b0);

      // reset state with a request pending
      @(negedge clk);
      chk("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
      chk("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
      chk("rst_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
      chk("rst_rsp_id",     {31'd0, bus.rsp_id},     32'd0);
      chk("rst_rsp_s",      {28'd0, bus.rsp_s},      32'd0);
      chk("rst_rsp_c",      {31'd0, bus.rsp_c},      32'd0);
      chk("rst_rsp_v",      {31'd0, bus.rsp_v},      32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // directed add, then two subtracts on port 1
      bus.rsp_ready = 1'b1;
      eval_cycle();
      set_req(1'b0, 1'b0, '0, '0, 1'b0);
      set_req(1'b1, 1'b1, 4'b0111, 4'b1001, 1'b1);
      eval_cycle();
      set_req(1'b1, 1'b1, 4'b1001, 4'b0111, 1'b1);
      eval_cycle();
      set_req(1'b1, 1'b0, '0, '0, 1'b0);
      eval_cycle();

      // contention: both valid for six cycles, consumer always ready
      set_req(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      set_req(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      acc0 = 0;
      acc1 = 0;
      for (int i = 0; i < 6; i++) begin
         if (acc0) set_req(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
         if (acc1) set_req(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
         eval_cycle();
      end

      // backpressure: register full, consumer stalls three cycles, then resumes
      if (acc0) set_req(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      if (acc1) set_req(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) eval_cycle();
      bus.rsp_ready = 1'b1;
      eval_cycle();
      set_req(1'b0, 1'b0, '0, '0, 1'b0);
      set_req(1'b1, 1'b0, '0, '0, 1'b0);
      eval_cycle();
      eval_cycle();

      // fairness across idle gaps: port 0 alone, idle, then a tie
      set_req(1'b0, 1'b1, 4'b0011, 4'b0101, 1'b0);
      eval_cycle();
      set_req(1'b0, 1'b0, '0, '0, 1'b0);
      eval_cycle();
      eval_cycle();
      set_req(1'b0, 1'b1, 4'b1000, 4'b0001, 1'b1);
      set_req(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0);
      eval_cycle();
      if (acc0) set_req(1'b0, 1'b0, '0, '0, 1'b0);
      if (acc1) set_req(1'b1, 1'b0, '0, '0, 1'b0);
      eval_cycle();
      set_req(1'b0, 1'b0, '0, '0, 1'b0);
      set_req(1'b1, 1'b0, '0, '0, 1'b0);
      eval_cycle();

      // random traffic with random consumer stalls
      for (int i = 0; i < 400; i++) begin
         drive_rand(60, 70);
         eval_cycle();
      end

      // mid-operation reset while full and stalled
      bus.rsp_ready = 1'b0;
      if (!bus.req0_valid || acc0) set_req(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      if (!bus.req1_valid || acc1) set_req(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      eval_cycle();
      eval_cycle();
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
      chk("arst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
      chk("arst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
      sbq.delete();
      full = 0;
      lg   = 1;
      acc0 = 0;
      acc1 = 0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      set_req(1'b0, 1'b1, 4'b0110, 4'b0011, 1'b1);
      set_req(1'b1, 1'b1, 4'b0101, 4'b0101, 1'b0);
      eval_cycle();
      chk("post_rst_tie_port0", {31'd0, acc0}, 32'd1);
      set_req(1'b0, 1'b0, '0, '0, 1'b0);
      set_req(1'b1, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 3; i++) eval_cycle();

      chk("outstanding_after_drain", sbq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard stop in case the main sequence never completes.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got time %0t required below 200000", $time);
      $fatal(1);
   end

endmodule
